oven_controller: RTL and testbench
==================================

# oven_controller

Top-level sequencing FSM for the microwave oven. It sits between the front panel (keypad, start/stop buttons, door switch) and the `timer` block. It drives the timer's load, clear and count-enable controls, and generates the one-second count tick with an internal prescaler. It also switches the magnetron and signals end of cooking. All timer-control outputs are registered, so timer actions trail the panel events by one cycle.

## Interface
- `TICKS_PER_SEC`, default 100: clock cycles per timer decrement. Minimum legal value is 2.
- `DONE_CYCLES`, default 50: cycles the `done` indication is held after cooking ends. Minimum legal value is 1.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `key_valid`  in  1  one-cycle strobe; `key_data` is valid.
- `key_data`  in  4  keypad digit.
- `start`  in  1  start/resume request (level, sampled every cycle).
- `stop`  in  1  pause/cancel request (level).
- `door_closed`  in  1  1 = door shut.
- `timer_zero`  in  1  timer `zero` output (1 at 0:00).
- `timer_data`  out  4  digit presented to timer `data`.
- `timer_loadn`  out  1  to timer `loadn`; active-low one-cycle load pulse.
- `timer_clrn`  out  1  to timer `clrn`; active-low one-cycle clear pulse.
- `timer_en`  out  1  to timer `en`; one-cycle decrement tick.
- `mag_on`  out  1  magnetron drive.
- `done`  out  1  cooking-finished indication.
- `state`  out  2  IDLE=0, COOK=1, PAUSE=2, DONE=3.

## Operation
**States**

- **IDLE**
  - Key entry is open here.
  - `stop` clears the timer and the digit count.
  - `start & door_closed & !timer_zero & !load_busy` goes to COOK.
- **COOK**
  - `mag_on` = 1 and the prescaler runs.
  - `!door_closed` or `stop` goes to PAUSE.
  - `timer_zero` goes to DONE.
- **PAUSE**
  - Magnetron is off and the prescaler count is held (not reset).
  - `stop` goes to IDLE with a timer clear.
  - `start & door_closed` goes back to COOK.
  - Keys are ignored.
- **DONE**
  - `done` = 1 and a hold counter loads `DONE_CYCLES`.
  - Expiry or `stop` goes to IDLE.
  - Keys and `start` are ignored.
  - The digit count is zeroed on exit.

**Key entry**

- Each accepted key produces one load pulse with `timer_data` = the key. The timer shifts digits in: new key → ones, ones → tens, tens → mins.
- A key is accepted only if all of the following hold:
  - `key_data` ≤ 9;
  - `digit_count` < 3;
  - `digit_count` == 0 or `last_digit` ≤ 5 (the shifted digit must fit the mod-6 tens counter).
- Rejected keys cause no outputs and no state change.
- `digit_count` and `last_digit` update on acceptance.
- `load_busy` = 1 in the cycle the load pulse is driven and the cycle after, so `timer_zero` has settled before `start` is honoured.

**Priority**

- `clr` overrides everything.
- Door-open and `stop` take priority over `start`.
- `start` takes priority over `key_valid` in the same cycle; the key is dropped.

**Prescaler**

- Counts 0 … `TICKS_PER_SEC`-1 only in COOK.
- Pulses `timer_en` when it wraps.
- Cleared on entry to COOK from IDLE; held in PAUSE.

## Timing
- During `clr` and in the first cycle after release, `timer_clrn` = 0, clearing the timer.
- Reset values of all other outputs:
  - `state` = IDLE;
  - `timer_loadn` = 1, `timer_en` = 0;
  - `mag_on` = 0, `done` = 0;
  - `timer_data` = 0;
  - `digit_count` = 0, prescaler = 0.
- Key accepted at edge N: `timer_loadn` = 0 and `timer_data` = key during cycle N..N+1. The timer captures at edge N+1.
- `start` sampled at edge N gives `state` = COOK and `mag_on` = 1 from edge N.
- The first `timer_en` is asserted `TICKS_PER_SEC` cycles after COOK entry. Ticks then repeat every `TICKS_PER_SEC` cycles, with exactly one cycle high each.
- `timer_zero` sampled high in COOK gives DONE at the next edge: `mag_on` drops and `done` rises in the same cycle. No further `timer_en` is issued, which is guaranteed by `TICKS_PER_SEC` ≥ 2.
- DONE lasts exactly `DONE_CYCLES` cycles, then IDLE.
- The clear pulse on `stop` (IDLE/PAUSE) is one cycle of `timer_clrn` = 0, beginning the cycle after `stop` is sampled.
- A door opening in COOK drops `mag_on` at the next edge; `timer_en` is never asserted in PAUSE.
- `clr` mid-COOK: `mag_on` drops at the reset edge and the timer is cleared.

## Test plan
- Keys 1,3,0, wait 2 cycles, then `start` with `door_closed` (`TICKS_PER_SEC`=4) → three load pulses carrying 1,3,0; COOK; `timer_en` every 4 cycles; the timer counts 1:30 → 0:00; DONE for `DONE_CYCLES`; `done`=1 and `mag_on`=0; then IDLE.
- Key 7 then key 2 → second key rejected (7 > 5 cannot move to tens); only one load pulse. Key 12 → rejected. A fourth valid key → rejected.
- Cooking from 0:05, open the door after 2 ticks, close it, then `start` → PAUSE with `mag_on`=0 and no `timer_en`; on resume the remaining prescaler phase is honoured and the count continues from 0:03.
- `start` with `timer_zero`=1, or with the door open, or in the cycle right after a load → stays IDLE and `mag_on` stays 0.
- `stop` in PAUSE → one-cycle `timer_clrn`=0, IDLE, `digit_count`=0; a subsequent `start` is ignored because `timer_zero`=1.
- `clr` asserted mid-COOK → next cycle `state`=IDLE, `mag_on`=0, `timer_clrn`=0; all other outputs at their reset values.

Source files
------------

// File: rtl/oven_controller.sv
// Microwave oven sequencer: accepts keypad digits, runs the cook/pause/done flow,
// and drives the digit timer's load, clear and one-second decrement controls.
module oven_controller #(
   parameter int TICKS_PER_SEC = 100,
   parameter int DONE_CYCLES   = 50
) (
   input  logic       clock,
   input  logic       clr,
   input  logic       key_valid,
   input  logic [3:0] key_data,
   input  logic       start,
   input  logic       stop,
   input  logic       door_closed,
   input  logic       timer_zero,
   output logic [3:0] timer_data,
   output logic       timer_loadn,
   output logic       timer_clrn,
   output logic       timer_en,
   output logic       mag_on,
   output logic       done,
   output logic [1:0] state
);

   localparam int PW = $clog2(TICKS_PER_SEC);
   localparam int DW = $clog2(DONE_CYCLES + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [DW-1:0] HOLD_INIT  = DW'(DONE_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COOK  = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_reg;
   state_t        state_next;

   logic [PW-1:0] presc_reg;
   logic [DW-1:0] hold_reg;
   logic [1:0]    digit_count_reg;
   logic [3:0]    last_digit_reg;
   logic [3:0]    timer_data_reg;
   logic          timer_loadn_reg;
   logic          timer_clrn_reg;
   logic          timer_en_reg;
   logic          load_tail_reg;
   logic          post_rst_reg;

   logic          key_ok;
   logic          key_accept;
   logic          load_busy;
   logic          stop_clear;
   logic          cook_stay;
   logic          cook_from_idle;
   logic          presc_wrap;
   logic          digits_flush;

   // The shifted-out digit lands in the mod-6 tens stage, so it must be 5 or less.
   assign key_ok = (key_data <= 4'd9) && (digit_count_reg < 2'd3) &&
                   ((digit_count_reg == 2'd0) || (last_digit_reg <= 4'd5));
   assign key_accept = (state_reg == S_IDLE) && key_valid && !start && !stop && key_ok;

   // Busy while the load pulse is out and one cycle more, so timer_zero has settled.
   assign load_busy = !timer_loadn_reg || load_tail_reg;

   assign stop_clear     = stop && ((state_reg == S_IDLE) || (state_reg == S_PAUSE));
   assign cook_stay      = (state_reg == S_COOK) && (state_next == S_COOK);
   assign cook_from_idle = (state_reg == S_IDLE) && (state_next == S_COOK);
   assign presc_wrap     = cook_stay && (presc_reg == PRESC_LAST);
   assign digits_flush   = stop_clear || ((state_reg == S_DONE) && (state_next == S_IDLE));

   always_ff @(posedge clock) begin
      if (clr) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (!stop && start && door_closed && !timer_zero && !load_busy) begin
               state_next = S_COOK;
            end
         end
         S_COOK: begin
            if (!door_closed || stop) begin
               state_next = S_PAUSE;
            end else if (timer_zero) begin
               state_next = S_DONE;
            end
         end
         S_PAUSE: begin
            if (stop) begin
               state_next = S_IDLE;
            end else if (start && door_closed) begin
               state_next = S_COOK;
            end
         end
         default: begin
            if (stop || (hold_reg == DW'(1))) begin
               state_next = S_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      state       = state_reg;
      mag_on      = (state_reg == S_COOK);
      done        = (state_reg == S_DONE);
      timer_data  = timer_data_reg;
      timer_loadn = timer_loadn_reg;
      timer_clrn  = timer_clrn_reg;
      timer_en    = timer_en_reg;
   end

   always_ff @(posedge clock) begin
      if (clr) begin
         presc_reg       <= '0;
         hold_reg        <= '0;
         digit_count_reg <= '0;
         last_digit_reg  <= '0;
         timer_data_reg  <= '0;
         timer_loadn_reg <= 1'b1;
         timer_clrn_reg  <= 1'b0;
         timer_en_reg    <= 1'b0;
         load_tail_reg   <= 1'b0;
         post_rst_reg    <= 1'b1;
      end else begin
         // Clear stays asserted for one cycle beyond reset release.
         post_rst_reg    <= 1'b0;
         timer_clrn_reg  <= !(post_rst_reg || stop_clear);
         timer_loadn_reg <= !key_accept;
         load_tail_reg   <= !timer_loadn_reg;
         timer_en_reg    <= presc_wrap;

         if (key_accept) begin
            timer_data_reg <= key_data;
         end

         if (digits_flush) begin
            digit_count_reg <= '0;
         end else if (key_accept) begin
            digit_count_reg <= digit_count_reg + 2'd1;
            last_digit_reg  <= key_data;
         end

         // Only cycles that stay in COOK advance the phase; PAUSE holds it.
         if (cook_from_idle) begin
            presc_reg <= '0;
         end else if (presc_wrap) begin
            presc_reg <= '0;
         end else if (cook_stay) begin
            presc_reg <= presc_reg + PW'(1);
         end

         if ((state_next == S_DONE) && (state_reg != S_DONE)) begin
            hold_reg <= HOLD_INIT;
         end else if (state_reg == S_DONE) begin
            hold_reg <= hold_reg - DW'(1);
         end
      end
   end

endmodule

// File: tb/tb_oven_controller.sv
// Bench for oven_controller: digit-timer model plus a rule-level reference of the
// controller, directed steps followed by a randomized panel sequence.
module tb_oven_controller;

   localparam int T = 4;
   localparam int D = 6;
   localparam int M_IDLE  = 0;
   localparam int M_COOK  = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic       clock = 1'b0;
   logic       clr;
   logic       key_valid;
   logic [3:0] key_data;
   logic       start;
   logic       stop;
   logic       door_closed;
   logic       timer_zero;
   logic [3:0] timer_data;
   logic       timer_loadn;
   logic       timer_clrn;
   logic       timer_en;
   logic       mag_on;
   logic       done;
   logic [1:0] state;

   int n_checks = 0;
   int n_errors = 0;
   int en_seen = 0;
   int loads_seen = 0;

   always #5 clock = ~clock;

   oven_controller #(
      .TICKS_PER_SEC(T),
      .DONE_CYCLES(D)
   ) dut (
      .clock(clock),
      .clr(clr),
      .key_valid(key_valid),
      .key_data(key_data),
      .start(start),
      .stop(stop),
      .door_closed(door_closed),
      .timer_zero(timer_zero),
      .timer_data(timer_data),
      .timer_loadn(timer_loadn),
      .timer_clrn(timer_clrn),
      .timer_en(timer_en),
      .mag_on(mag_on),
      .done(done),
      .state(state)
   );

   // m:ss digit timer driven by the controller
   int t_min = 0;
   int t_ten = 0;
   int t_one = 0;
   assign timer_zero = (t_min == 0) && (t_ten == 0) && (t_one == 0);

   always @(posedge clock) begin
      if (timer_clrn === 1'b0) begin
         t_min <= 0;
         t_ten <= 0;
         t_one <= 0;
      end else if (timer_loadn === 1'b0) begin
         t_min <= t_ten;
         t_ten <= t_one;
         t_one <= int'(timer_data);
      end else if (timer_en === 1'b1 && !timer_zero) begin
         if (t_one > 0) begin
            t_one <= t_one - 1;
         end else begin
            t_one <= 9;
            if (t_ten > 0) begin
               t_ten <= t_ten - 1;
            end else begin
               t_ten <= 5;
               t_min <= t_min - 1;
            end
         end
      end
   end

   function automatic int tval();
      return t_min * 100 + t_ten * 10 + t_one;
   endfunction

   // reference model state
   int         m_state = M_IDLE;
   int         m_phase = 0;
   int         m_hold = 0;
   int         m_load_age = 2;
   bit         m_after_rst = 1'b0;
   int         keys[$];
   logic       exp_loadn = 1'b1;
   logic       exp_clrn = 1'b0;
   logic       exp_en = 1'b0;
   logic [3:0] exp_data = 4'd0;

   task automatic model_edge();
      int nxt;
      bit acc;
      bit clear_pulse;
      if (clr === 1'b1) begin
         m_state = M_IDLE;
         m_phase = 0;
         m_hold = 0;
         m_load_age = 2;
         m_after_rst = 1'b1;
         keys.delete();
         exp_loadn = 1'b1;
         exp_clrn = 1'b0;
         exp_en = 1'b0;
         exp_data = 4'd0;
      end else begin
         nxt = m_state;
         acc = 1'b0;
         clear_pulse = m_after_rst;
         m_after_rst = 1'b0;
         exp_en = 1'b0;
         case (m_state)
            M_IDLE: begin
               if (stop) begin
                  clear_pulse = 1'b1;
                  keys.delete();
               end else if (start) begin
                  if (door_closed && !timer_zero && m_load_age >= 2) nxt = M_COOK;
               end else if (key_valid && int'(key_data) <= 9 && keys.size() < 3 &&
                            (keys.size() == 0 || keys[$] <= 5)) begin
                  acc = 1'b1;
                  keys.push_back(int'(key_data));
               end
            end
            M_COOK: begin
               if (!door_closed || stop) nxt = M_PAUSE;
               else if (timer_zero) nxt = M_DONE;
            end
            M_PAUSE: begin
               if (stop) begin
                  nxt = M_IDLE;
                  clear_pulse = 1'b1;
                  keys.delete();
               end else if (start && door_closed) begin
                  nxt = M_COOK;
               end
            end
            default: begin
               if (stop || m_hold == 1) begin
                  nxt = M_IDLE;
                  keys.delete();
               end
            end
         endcase
         if (m_state == M_IDLE && nxt == M_COOK) begin
            m_phase = 0;
         end else if (m_state == M_COOK && nxt == M_COOK) begin
            m_phase++;
            if (m_phase == T) begin
               m_phase = 0;
               exp_en = 1'b1;
            end
         end
         if (nxt == M_DONE && m_state != M_DONE) m_hold = D;
         else if (m_state == M_DONE) m_hold--;
         m_load_age = acc ? 0 : ((m_load_age >= 2) ? 2 : m_load_age + 1);
         exp_loadn = !acc;
         if (acc) exp_data = key_data;
         exp_clrn = !clear_pulse;
         m_state = nxt;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("state", 32'(state), m_state);
      check("mag_on", 32'(mag_on), (m_state == M_COOK) ? 1 : 0);
      check("done", 32'(done), (m_state == M_DONE) ? 1 : 0);
      check("timer_loadn", 32'(timer_loadn), 32'(exp_loadn));
      check("timer_clrn", 32'(timer_clrn), 32'(exp_clrn));
      check("timer_en", 32'(timer_en), 32'(exp_en));
      check("timer_data", 32'(timer_data), 32'(exp_data));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clock);
      #1;
      if (timer_en === 1'b1) en_seen++;
      if (timer_loadn === 1'b0) loads_seen++;
      compare_all();
   endtask

   task automatic press(input int k);
      key_valid = 1'b1;
      key_data = 4'(k);
      tick();
      key_valid = 1'b0;
   endtask

   task automatic run_until(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (32'(state) == target) break;
         tick();
      end
      check("reach_state", 32'(state), target);
   endtask

   initial begin
      int l0;
      int e0;
      int e1;
      int d;

      clr = 1'b1;
      key_valid = 1'b0;
      key_data = 4'd0;
      start = 1'b0;
      stop = 1'b0;
      door_closed = 1'b1;

      $display("step: reset");
      repeat (3) tick();
      check("rst_state", 32'(state), M_IDLE);
      check("rst_loadn", 32'(timer_loadn), 1);
      check("rst_clrn", 32'(timer_clrn), 0);
      check("rst_en", 32'(timer_en), 0);
      check("rst_mag", 32'(mag_on), 0);
      check("rst_done", 32'(done), 0);
      check("rst_data", 32'(timer_data), 0);
      clr = 1'b0;
      tick();
      check("rst_clrn_after_release", 32'(timer_clrn), 0);
      tick();
      check("rst_clrn_end", 32'(timer_clrn), 1);

      $display("step: keys 1,3,0 then cook 1:30");
      l0 = loads_seen;
      press(1); tick(); press(3); tick(); press(0);
      tick(); tick();
      check("loads_130", loads_seen - l0, 3);
      check("timer_130", tval(), 130);
      start = 1'b1; tick(); start = 1'b0;
      check("cook_entry", 32'(state), M_COOK);
      check("cook_mag", 32'(mag_on), 1);
      e0 = en_seen;
      run_until(M_DONE, 600);
      check("ticks_130", en_seen - e0, 90);
      check("done_flag", 32'(done), 1);
      check("done_mag", 32'(mag_on), 0);
      d = 1;
      for (int i = 0; i < 50 && state === 2'd3; i++) begin
         tick();
         if (state === 2'd3) d++;
      end
      check("done_cycles", d, D);
      check("done_exit", 32'(state), M_IDLE);

      $display("step: key rejection");
      l0 = loads_seen;
      press(7); tick(); press(2); tick(); press(12); tick(); tick();
      check("reject_loads", loads_seen - l0, 1);
      check("reject_timer", tval(), 7);
      stop = 1'b1; tick(); stop = 1'b0;
      check("idle_stop_clrn", 32'(timer_clrn), 0);
      tick();
      check("idle_stop_clrn_end", 32'(timer_clrn), 1);
      check("idle_stop_timer", tval(), 0);
      l0 = loads_seen;
      press(1); tick(); press(2); tick(); press(3); tick(); press(4); tick(); tick();
      check("fourth_key_loads", loads_seen - l0, 3);
      check("fourth_key_timer", tval(), 123);

      $display("step: pause and resume from 0:05");
      stop = 1'b1; tick(); stop = 1'b0; tick();
      press(5); tick(); tick();
      start = 1'b1; tick(); start = 1'b0;
      check("pause_cook_entry", 32'(state), M_COOK);
      e0 = en_seen;
      for (int i = 0; i < 40 && (en_seen - e0) < 2; i++) tick();
      check("pause_two_ticks", en_seen - e0, 2);
      door_closed = 1'b0; tick();
      check("pause_state", 32'(state), M_PAUSE);
      check("pause_mag", 32'(mag_on), 0);
      check("pause_timer", tval(), 3);
      e1 = en_seen;
      repeat (8) tick();
      check("pause_no_ticks", en_seen - e1, 0);
      door_closed = 1'b1; tick();
      start = 1'b1; tick(); start = 1'b0;
      check("resume_state", 32'(state), M_COOK);
      run_until(M_DONE, 200);
      check("resume_ticks", en_seen - e1, 3);
      run_until(M_IDLE, 50);

      $display("step: blocked starts");
      start = 1'b1; tick(); start = 1'b0;
      check("start_zero_state", 32'(state), M_IDLE);
      check("start_zero_mag", 32'(mag_on), 0);
      press(5); tick(); tick(); tick();
      door_closed = 1'b0; start = 1'b1; tick(); start = 1'b0; door_closed = 1'b1;
      check("start_door_state", 32'(state), M_IDLE);
      check("start_door_mag", 32'(mag_on), 0);
      press(3);
      start = 1'b1; tick(); start = 1'b0;
      check("start_busy_state", 32'(state), M_IDLE);
      check("start_busy_mag", 32'(mag_on), 0);

      $display("step: stop in pause");
      tick(); tick();
      start = 1'b1; tick(); start = 1'b0;
      check("sp_cook", 32'(state), M_COOK);
      repeat (5) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      check("sp_pause", 32'(state), M_PAUSE);
      tick();
      stop = 1'b1; tick(); stop = 1'b0;
      check("sp_idle", 32'(state), M_IDLE);
      check("sp_clrn", 32'(timer_clrn), 0);
      tick();
      check("sp_clrn_end", 32'(timer_clrn), 1);
      check("sp_timer", tval(), 0);
      start = 1'b1; tick(); start = 1'b0;
      check("sp_start_ignored", 32'(state), M_IDLE);
      l0 = loads_seen;
      press(1); tick(); press(2); tick(); press(3); tick(); tick();
      check("sp_digits_flushed", loads_seen - l0, 3);
      check("sp_timer_123", tval(), 123);

      $display("step: clr during cook");
      start = 1'b1; tick(); start = 1'b0;
      check("clr_cook", 32'(state), M_COOK);
      repeat (6) tick();
      clr = 1'b1; tick();
      check("clr_state", 32'(state), M_IDLE);
      check("clr_mag", 32'(mag_on), 0);
      check("clr_clrn", 32'(timer_clrn), 0);
      check("clr_data", 32'(timer_data), 0);
      clr = 1'b0; tick();
      check("clr_clrn_after", 32'(timer_clrn), 0);
      tick();
      check("clr_timer", tval(), 0);

      $display("step: randomized panel activity");
      for (int i = 0; i < 3000; i++) begin
         key_valid = ($urandom_range(0, 5) == 0);
         key_data = 4'($urandom_range(0, 11));
         start = ($urandom_range(0, 11) == 0);
         stop = !key_valid && ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 29) == 0) door_closed = !door_closed;
         tick();
      end
      key_valid = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
